gfx_pixel_rmw: RTL and testbench
================================

Name: gfx_pixel_rmw

Overview:
- Downstream of the pixel address calculator: consumes strip address, mask-begin and mask-end, plus a pixel colour and raster op.
- Performs a read-modify-write of one SW-bit memory strip so that only bits [me:mb] change.
- Sits between the drawing engines and the video memory bus master.
- Optional single-strip write-combine buffer avoids re-reading a strip for consecutive pixels in it.

Parameters:
- SW, 128, strip width in bits (memory data width).
- BN, 6, msb index of mask bit positions (log2(SW)-1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid_i  in  1  pixel request valid.
- req_ready_o  out  1  block accepts request this cycle.
- req_address_i  in  32  strip byte address (16-byte aligned).
- req_mb_i  in  BN+1  mask begin bit.
- req_me_i  in  BN+1  mask end bit (inclusive).
- req_color_i  in  32  pixel value, right-justified.
- req_op_i  in  2  raster op: 00 copy, 01 AND, 10 OR, 11 XOR.
- flush_i  in  1  write back held strip (write-combine builds only).
- mem_cyc_o  out  1  bus cycle active.
- mem_we_o  out  1  write strobe.
- mem_sel_o  out  SW/8  byte selects.
- mem_adr_o  out  32  bus address.
- mem_dat_o  out  SW  write data.
- mem_dat_i  in  SW  read data.
- mem_ack_i  in  1  bus acknowledge.
- idle_o  out  1  no request in progress, no dirty strip held.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - req_ready_o=1, idle_o=1.
  - mem_cyc_o=0, mem_we_o=0, mem_sel_o=0, mem_adr_o=0, mem_dat_o=0.
  - Held strip invalid. Reset mid-bus-cycle drops mem_cyc_o immediately; held data is discarded.
- Handshake:
  - A request transfers when req_valid_i && req_ready_o at a rising edge.
  - All req_* fields are latched on transfer.
  - req_ready_o=1 only in IDLE, and in HOLD when flush_i=0.
- Mask:
  - mask[i]=1 for mb<=i<=me.
  - If me<mb (overflow), mask covers mb..SW-1.
  - Bits of me beyond SW-1 are ignored.
- Colour alignment: shifted = {SW-32 zeros, color} << mb, truncated to SW bits.
- Merge: new = (old & ~mask) | (f(old, shifted) & mask).
  - f = shifted for copy; old&shifted for AND; old|shifted for OR; old^shifted for XOR.
- States: IDLE, READ, MODIFY, WRITE, plus HOLD in write-combine builds.
- IDLE: on transfer go to READ.
- READ:
  - mem_cyc_o=1, mem_we_o=0, mem_sel_o all ones, mem_adr_o=latched address.
  - On mem_ack_i, latch mem_dat_i into the strip register, drop cyc the next cycle, go to MODIFY.
- MODIFY: one cycle, strip register <= merge result, then go to WRITE (base build).
- WRITE:
  - mem_cyc_o=1, mem_we_o=1, mem_sel_o all ones, mem_dat_o=strip register.
  - On ack: go to IDLE (base build); go to READ if a pending request is latched (write-combine build).
- Latency, base build, zero-wait bus (ack one cycle after cyc rises):
  - Transfer to write-ack is 5 cycles.
  - Back-to-back throughput is 1 pixel per 6 cycles.
- mem_cyc_o never deasserts before ack. Outputs are stable while cyc is high.
- idle_o=1 only in IDLE.

Optional Feature:
- Macro: GFX_PIXEL_RMW_WRITE_COMBINE_EN.
- Enabled:
  - MODIFY goes to HOLD instead of WRITE. The dirty strip is kept; idle_o=0 in HOLD.
  - HOLD, request with the same address: transfers; strip is merged in MODIFY with no bus traffic; back to HOLD (2 cycles per pixel).
  - HOLD, request with a different address: transfers and is latched as pending; go to WRITE, then READ for the new address.
  - HOLD with flush_i=1: req_ready_o=0 (flush wins over a simultaneous request); go to WRITE, then IDLE.
  - flush_i in IDLE, READ, MODIFY or WRITE: no effect.
- Disabled:
  - HOLD state absent; flush_i ignored.
  - Every pixel costs one read plus one write.

Test Plan:
- Reset, then copy request: addr 0x1000, mb=16, me=31, color 0xABCD, memory 0xFFFF...FF -> read of 0x1000, then write of 0x1000 with bits[31:16]=0xABCD and all others 1; idle_o returns to 1.
- XOR: mb=120, me=127, color 0xFF, old bits[127:120]=0x0F -> written bits[127:120]=0xF0, bits[119:0] unchanged.
- Wrap: mb=124, me=3 (overflow) -> only bits[127:124] modified.
- Bus stall: ack delayed 7 cycles in READ and in WRITE -> cyc, adr and dat held stable; req_ready_o=0 throughout; exactly one write.
- Write-combine build: three copies to 0x2000 at mb=0, 16, 32, then flush_i -> one read, one write of 0x2000 containing all three pixels.
- Async reset during WRITE (rst_n low for 1 cycle) -> mem_cyc_o=0 the same cycle; after release state IDLE, req_ready_o=1, no further bus cycles.

Source files
------------

// File: rtl/gfx_pixel_rmw_if.sv
`default_nettype none
// =====================================================================
// gfx_pixel_rmw_if : pixel request and memory-bus bundle for gfx_pixel_rmw
// Rev 1.0
// =====================================================================
interface gfx_pixel_rmw_if #(
    parameter int SW = 128,
    parameter int BN = 6
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [31:0]     req_address_i;
    logic [BN:0]     req_mb_i;
    logic [BN:0]     req_me_i;
    logic [31:0]     req_color_i;
    logic [1:0]      req_op_i;
    logic            flush_i;
    logic            mem_cyc_o;
    logic            mem_we_o;
    logic [SW/8-1:0] mem_sel_o;
    logic [31:0]     mem_adr_o;
    logic [SW-1:0]   mem_dat_o;
    logic [SW-1:0]   mem_dat_i;
    logic            mem_ack_i;
    logic            idle_o;

    modport slave (
        input  req_valid_i, req_address_i, req_mb_i, req_me_i, req_color_i, req_op_i,
        input  flush_i, mem_dat_i, mem_ack_i,
        output req_ready_o, mem_cyc_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o, idle_o
    );

    modport master (
        output req_valid_i, req_address_i, req_mb_i, req_me_i, req_color_i, req_op_i,
        output flush_i, mem_dat_i, mem_ack_i,
        input  req_ready_o, mem_cyc_o, mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o, idle_o
    );
endinterface
`default_nettype wire

// File: rtl/gfx_pixel_rmw.sv
`default_nettype none
// =====================================================================
// gfx_pixel_rmw : read-modify-write of one SW-bit strip, only bits [me:mb] change.
// Optional write-combine buffer: GFX_PIXEL_RMW_WRITE_COMBINE_EN.  Rev 1.0
// =====================================================================
module gfx_pixel_rmw #(
    parameter int SW = 128,
    parameter int BN = 6
) (
    input wire             clk,
    input wire             rst_n,
    gfx_pixel_rmw_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_MODIFY = 3'd2,
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        S_HOLD   = 3'd4,
`endif
        S_WRITE  = 3'd3
    } state_t;

    localparam logic [BN:0] c_MSB = (BN+1)'(SW - 1);

    state_t        state_q, state_d;
    logic [31:0]   adr_q, strip_adr_q, color_q;
    logic [BN:0]   mb_q, me_q;
    logic [1:0]    op_q;
    logic [SW-1:0] strip_q;

    logic          w_take, w_load_rd, w_load_mod;
    logic          w_ready, w_cyc, w_we;
    logic [31:0]   w_adr;
    logic [SW-1:0] w_dat, w_mask, w_shift, w_f, w_merged;

`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
    logic pend_q, pend_d;
`else
    logic w_unused_flush;
    assign w_unused_flush = bus.flush_i;
`endif

    // me < mb means the span runs off the top of the strip
    always_comb begin
        w_mask  = ({SW{1'b1}} << mb_q) &
                  ((me_q < mb_q) ? {SW{1'b1}} : ({SW{1'b1}} >> (c_MSB - me_q)));
        w_shift = {{(SW-32){1'b0}}, color_q} << mb_q;
        case (op_q)
            2'b00:   w_f = w_shift;
            2'b01:   w_f = strip_q & w_shift;
            2'b10:   w_f = strip_q | w_shift;
            default: w_f = strip_q ^ w_shift;
        endcase
        w_merged = (strip_q & ~w_mask) | (w_f & w_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        w_ready    = 1'b0;
        w_take     = 1'b0;
        w_load_rd  = 1'b0;
        w_load_mod = 1'b0;
        w_cyc      = 1'b0;
        w_we       = 1'b0;
        w_adr      = '0;
        w_dat      = '0;
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        pend_d     = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid_i) begin
                    w_take  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                w_cyc = 1'b1;
                w_adr = adr_q;
                if (bus.mem_ack_i) begin
                    w_load_rd = 1'b1;
                    state_d   = S_MODIFY;
                end
            end
            S_MODIFY: begin
                w_load_mod = 1'b1;
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
                state_d    = S_HOLD;
`else
                state_d    = S_WRITE;
`endif
            end
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
            S_HOLD: begin
                w_ready = !bus.flush_i;
                if (bus.flush_i) begin
                    pend_d  = 1'b0;
                    state_d = S_WRITE;
                end else if (bus.req_valid_i) begin
                    w_take = 1'b1;
                    if (bus.req_address_i == strip_adr_q) begin
                        state_d = S_MODIFY;
                    end else begin
                        pend_d  = 1'b1;
                        state_d = S_WRITE;
                    end
                end
            end
`endif
            S_WRITE: begin
                w_cyc = 1'b1;
                w_we  = 1'b1;
                w_adr = strip_adr_q;
                w_dat = strip_q;
                if (bus.mem_ack_i) begin
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
                    pend_d  = 1'b0;
                    state_d = pend_q ? S_READ : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // strip_adr_q tracks the strip held in strip_q; adr_q may already name the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q       <= '0;
            strip_adr_q <= '0;
            color_q     <= '0;
            mb_q        <= '0;
            me_q        <= '0;
            op_q        <= '0;
            strip_q     <= '0;
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
            pend_q      <= 1'b0;
`endif
        end else begin
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
            pend_q <= pend_d;
`endif
            if (w_take) begin
                adr_q   <= bus.req_address_i;
                mb_q    <= bus.req_mb_i;
                me_q    <= bus.req_me_i;
                color_q <= bus.req_color_i;
                op_q    <= bus.req_op_i;
            end
            if (w_load_rd) begin
                strip_q     <= bus.mem_dat_i;
                strip_adr_q <= adr_q;
            end else if (w_load_mod) begin
                strip_q <= w_merged;
            end
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.mem_cyc_o   = w_cyc;
    assign bus.mem_we_o    = w_we;
    assign bus.mem_sel_o   = {(SW/8){w_cyc}};
    assign bus.mem_adr_o   = w_adr;
    assign bus.mem_dat_o   = w_dat;
    assign bus.idle_o      = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gfx_pixel_rmw.sv
`default_nettype none
// tb_gfx_pixel_rmw : scoreboard bench; expected bus transactions come from a
// bit-by-bit reference of the pixel merge rules and a simple strip-hold model.
module tb_gfx_pixel_rmw;
    localparam int SW = 128;
    localparam int BN = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gfx_pixel_rmw_if #(.SW(SW), .BN(BN)) bus ();
    gfx_pixel_rmw #(.SW(SW), .BN(BN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic we; logic [31:0] adr; logic [SW-1:0] dat; } txn_t;
    txn_t          exp_q[$];
    logic [SW-1:0] mem     [64];
    logic [SW-1:0] ref_mem [64];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_rd = 0;
    int            n_wr = 0;
    int            stall_cycles = 0;
    int            stall_cnt = 0;
    time           xfer_time = 0;
    time           wr_time = 0;
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
    logic          held_v = 1'b0;
    logic [31:0]   held_a = '0;
`endif

    function automatic logic [5:0] idx(input logic [31:0] a);
        return {a[13:12], a[7:4]};
    endfunction

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference merge: each bit decided independently from the pixel rules
    function automatic logic [SW-1:0] ref_merge(input logic [SW-1:0] old, input int mb, input int me,
                                                input logic [31:0] col, input logic [1:0] op);
        logic [SW-1:0] r;
        logic in_m, s, f;
        for (int i = 0; i < SW; i++) begin
            in_m = (me >= mb) ? (i >= mb && i <= me) : (i >= mb);
            s    = (i >= mb && i - mb < 32) ? col[i - mb] : 1'b0;
            case (op)
                2'b00:   f = s;
                2'b01:   f = old[i] & s;
                2'b10:   f = old[i] | s;
                default: f = old[i] ^ s;
            endcase
            r[i] = in_m ? f : old[i];
        end
        return r;
    endfunction

    task automatic push(input logic we, input logic [31:0] a, input logic [SW-1:0] d);
        txn_t t;
        t.we = we; t.adr = a; t.dat = d;
        exp_q.push_back(t);
    endtask

    task automatic model_update(input logic [31:0] a, input int mb, input int me,
                                input logic [31:0] col, input logic [1:0] op);
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        if (!(held_v && held_a == a)) begin
            if (held_v) push(1'b1, held_a, ref_mem[idx(held_a)]);
            push(1'b0, a, '0);
        end
        held_v = 1'b1;
        held_a = a;
        ref_mem[idx(a)] = ref_merge(ref_mem[idx(a)], mb, me, col, op);
`else
        push(1'b0, a, '0);
        ref_mem[idx(a)] = ref_merge(ref_mem[idx(a)], mb, me, col, op);
        push(1'b1, a, ref_mem[idx(a)]);
`endif
    endtask

    task automatic issue(input logic [31:0] a, input int mb, input int me,
                         input logic [31:0] col, input logic [1:0] op);
        int g = 0;
        @(negedge clk);
        bus.req_valid_i   = 1'b1;
        bus.req_address_i = a;
        bus.req_mb_i      = 7'(mb);
        bus.req_me_i      = 7'(me);
        bus.req_color_i   = col;
        bus.req_op_i      = op;
        while (!bus.req_ready_o && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (!bus.req_ready_o) begin
            n_checks++; n_errors++;
            $display("FAIL req_accept_timeout: req_ready_o=0 after %0d cycles, required 1", g);
            bus.req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        xfer_time = $time;
        #1 bus.req_valid_i = 1'b0;
        model_update(a, mb, me, col, op);
    endtask

    task automatic drain();
        int g = 0;
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        @(negedge clk);
        bus.flush_i = 1'b1;
        if (held_v) push(1'b1, held_a, ref_mem[idx(held_a)]);
        held_v = 1'b0;
`endif
        @(negedge clk);
        while (!(bus.idle_o && exp_q.size() == 0) && g < 400) begin
            @(negedge clk);
            g++;
        end
        bus.flush_i = 1'b0;
        n_checks++;
        if (!(bus.idle_o && exp_q.size() == 0)) begin
            n_errors++;
            $display("FAIL drain_timeout: idle_o=%0b pending=%0d, required idle_o=1 pending=0",
                     bus.idle_o, exp_q.size());
        end
    endtask

    // Memory responder: ack one cycle after cyc plus stall_cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_ack_i <= 1'b0;
            bus.mem_dat_i <= '0;
            stall_cnt     <= 0;
        end else if (bus.mem_ack_i) begin
            bus.mem_ack_i <= 1'b0;
            stall_cnt     <= 0;
            if (bus.mem_we_o) mem[idx(bus.mem_adr_o)] <= bus.mem_dat_o;
        end else if (bus.mem_cyc_o) begin
            if (stall_cnt >= stall_cycles) begin
                bus.mem_ack_i <= 1'b1;
                if (!bus.mem_we_o) bus.mem_dat_i <= mem[idx(bus.mem_adr_o)];
            end else begin
                stall_cnt <= stall_cnt + 1;
            end
        end
    end

    logic          prev_cyc = 1'b0;
    logic          p_we;
    logic [31:0]   p_adr;
    logic [15:0]   p_sel;
    logic [SW-1:0] p_dat;

    always @(negedge clk) begin : monitor
        txn_t t;
        if (!rst_n) begin
            prev_cyc = 1'b0;
        end else begin
            if (bus.mem_cyc_o) begin
                chk("ready_low_in_bus_cycle", SW'(bus.req_ready_o), SW'(0));
                if (prev_cyc) begin
                    chk("stable_adr", SW'(bus.mem_adr_o), SW'(p_adr));
                    chk("stable_we",  SW'(bus.mem_we_o),  SW'(p_we));
                    chk("stable_sel", SW'(bus.mem_sel_o), SW'(p_sel));
                    chk("stable_dat", bus.mem_dat_o, p_dat);
                end
                prev_cyc = 1'b1;
                p_adr = bus.mem_adr_o; p_we = bus.mem_we_o;
                p_sel = bus.mem_sel_o; p_dat = bus.mem_dat_o;
            end else begin
                prev_cyc = 1'b0;
            end
            if (bus.mem_cyc_o && bus.mem_ack_i) begin
                prev_cyc = 1'b0;
                if (bus.mem_we_o) begin
                    n_wr++;
                    wr_time = $time + 5;
                end else begin
                    n_rd++;
                end
                chk("txn_sel_all_ones", SW'(bus.mem_sel_o), SW'(16'hFFFF));
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_txn: we=%0b adr=%h, required no transaction",
                             bus.mem_we_o, bus.mem_adr_o);
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_we",  SW'(bus.mem_we_o),  SW'(t.we));
                    chk("txn_adr", SW'(bus.mem_adr_o), SW'(t.adr));
                    if (t.we) chk("txn_wdat", bus.mem_dat_o, t.dat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [SW-1:0] orig, saved;
        logic [31:0]   col;
        logic [15:0]   c0, c1, c2;
        time           t0;
        int            r0, w0, seen;

        bus.req_valid_i = 1'b0; bus.req_address_i = '0; bus.req_mb_i = '0;
        bus.req_me_i = '0; bus.req_color_i = '0; bus.req_op_i = '0; bus.flush_i = 1'b0;
        for (int k = 0; k < 64; k++) begin
            mem[k]     = {$urandom, $urandom, $urandom, $urandom};
            ref_mem[k] = mem[k];
        end
        mem[idx(32'h1000)]     = {SW{1'b1}};
        ref_mem[idx(32'h1000)] = {SW{1'b1}};
        mem[idx(32'h1010)][127:120]     = 8'h0F;
        ref_mem[idx(32'h1010)][127:120] = 8'h0F;

        repeat (3) @(negedge clk);
        chk("rst_ready", SW'(bus.req_ready_o), SW'(1));
        chk("rst_idle",  SW'(bus.idle_o),      SW'(1));
        chk("rst_cyc",   SW'(bus.mem_cyc_o),   SW'(0));
        chk("rst_we",    SW'(bus.mem_we_o),    SW'(0));
        chk("rst_sel",   SW'(bus.mem_sel_o),   SW'(0));
        chk("rst_adr",   SW'(bus.mem_adr_o),   SW'(0));
        chk("rst_dat",   bus.mem_dat_o,        SW'(0));
        rst_n = 1'b1;

        // Copy into an all-ones strip
        issue(32'h1000, 16, 31, 32'h0000_ABCD, 2'b00);
        drain();
        chk("copy_result", mem[idx(32'h1000)], 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_ABCD_FFFF);
        chk("idle_after_copy", SW'(bus.idle_o), SW'(1));
`ifndef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        chk("xfer_to_wack_cycles", SW'((wr_time - xfer_time) / 10), SW'(5));
`endif

        // XOR top byte, then overflow span, issued back to back
        orig = mem[idx(32'h1010)];
        saved = mem[idx(32'h1020)];
        col = $urandom;
        issue(32'h1010, 120, 127, 32'h0000_00FF, 2'b11);
        t0 = xfer_time;
        issue(32'h1020, 124, 3, col, 2'b00);
`ifndef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        chk("back_to_back_cycles", SW'((xfer_time - t0) / 10), SW'(6));
`endif
        drain();
        chk("xor_top_byte", SW'(mem[idx(32'h1010)][127:120]), SW'(8'hF0));
        chk("xor_low_kept", SW'(mem[idx(32'h1010)][119:0]), SW'(orig[119:0]));
        chk("wrap_top_nibble", SW'(mem[idx(32'h1020)][127:124]), SW'(col[3:0]));
        chk("wrap_low_kept", SW'(mem[idx(32'h1020)][123:0]), SW'(saved[123:0]));

        // Long bus stall on both read and write
        stall_cycles = 7;
        r0 = n_rd; w0 = n_wr;
        issue(32'h1030, $urandom_range(0, 127), $urandom_range(0, 127), $urandom, 2'($urandom_range(0, 3)));
        drain();
        chk("stall_one_read",  SW'(n_rd - r0), SW'(1));
        chk("stall_one_write", SW'(n_wr - w0), SW'(1));
        stall_cycles = 0;

`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        // Three pixels into one held strip, then flush
        c0 = 16'($urandom); c1 = 16'($urandom); c2 = 16'($urandom);
        r0 = n_rd; w0 = n_wr;
        issue(32'h2000, 0, 15, {16'h0, c0}, 2'b00);
        issue(32'h2000, 16, 31, {16'h0, c1}, 2'b00);
        t0 = xfer_time;
        issue(32'h2000, 32, 47, {16'h0, c2}, 2'b00);
        chk("combine_cycles_per_pixel", SW'((xfer_time - t0) / 10), SW'(2));
        drain();
        chk("combine_one_read",  SW'(n_rd - r0), SW'(1));
        chk("combine_one_write", SW'(n_wr - w0), SW'(1));
        chk("combine_data", SW'(mem[idx(32'h2000)][47:0]), SW'({c2, c1, c0}));
`else
        c0 = 16'h0; c1 = 16'h0; c2 = 16'h0;
`endif

        for (int n = 0; n < 40; n++) begin
            stall_cycles = $urandom_range(0, 2);
            issue(32'h3000 + 32'(16 * $urandom_range(0, 2)), $urandom_range(0, 127),
                  $urandom_range(0, 127), $urandom, 2'($urandom_range(0, 3)));
        end
        drain();
        stall_cycles = 0;

        // Asynchronous reset while a write is stalled on the bus
        stall_cycles = 6;
        saved = ref_mem[idx(32'h1040)];
        issue(32'h1040, 8, 40, $urandom, 2'b10);
`ifdef GFX_PIXEL_RMW_WRITE_COMBINE_EN
        @(negedge clk);
        bus.flush_i = 1'b1;
        held_v = 1'b0;
`endif
        seen = 0;
        while (!(bus.mem_cyc_o && bus.mem_we_o) && seen < 100) begin
            @(negedge clk);
            seen++;
        end
        chk("write_reached", SW'(bus.mem_cyc_o && bus.mem_we_o), SW'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_drops_cyc", SW'(bus.mem_cyc_o), SW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.flush_i = 1'b0;
        exp_q.delete();
        ref_mem[idx(32'h1040)] = saved;
        stall_cycles = 0;
        chk("post_rst_ready", SW'(bus.req_ready_o), SW'(1));
        chk("post_rst_idle",  SW'(bus.idle_o),      SW'(1));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_cyc_o) seen++;
        end
        chk("post_rst_no_bus", SW'(seen), SW'(0));
        chk("post_rst_mem_kept", mem[idx(32'h1040)], saved);

        issue(32'h1050, 64, 95, $urandom, 2'b01);
        drain();
        chk("queue_empty", SW'(exp_q.size()), SW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
